cv32e40p_apu_router: RTL and testbench
======================================

CV32E40P_APU_ROUTER -- requirements
Module: cv32e40p_apu_router

Interface
REQ-001 Parameters: N_UNITS, default 2, number of APU units (1..4); DEPTH, default 4, max outstanding operations (power of 2, 2..8); UW = max(1, clog2(N_UNITS)).
REQ-002 Port widths APU_NARGS_CPU, APU_WOP_CPU, APU_NDSFLAGS_CPU and APU_NUSFLAGS_CPU SHALL come from cv32e40p_apu_core_pkg.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 Core side: apu_req_i in 1; apu_gnt_o out 1; apu_operands_i in NARGS x 32; apu_op_i in WOP; apu_flags_i in NDSFLAGS.
REQ-006 Core side: apu_rvalid_o out 1; apu_result_o out 32; apu_rflags_o out NUSFLAGS.
REQ-007 Unit side, per unit u: unit_req_o[u], unit_gnt_i[u], unit_operands_o, unit_op_o, unit_flags_o (broadcast), unit_rvalid_i[u], unit_result_i[u], unit_rflags_i[u].
REQ-008 unit_clk_en_o  out  N_UNITS  per-unit clock-gate enable.
REQ-009 err_unit_o  out  1  sticky flag, set on an out-of-range unit select.

Function
REQ-010 Unit select SHALL be sel = apu_op_i[WOP-1 -: UW]; 0 when N_UNITS = 1.
REQ-011 Space SHALL be true when the order FIFO is not full and outstanding[sel] < DEPTH. Both values are registered, so a retire in the same cycle does not free space.
REQ-012 unit_req_o[sel] = apu_req_i & space & (sel < N_UNITS), combinationally.
REQ-013 apu_gnt_o SHALL equal unit_req_o[sel] & unit_gnt_i[sel], zero-cycle.
REQ-014 Operands, op and flags SHALL pass through combinationally to all units.
REQ-015 Out-of-range sel with apu_req_i & space: apu_gnt_o = 1 the same cycle; no unit request is issued; err_unit_o is set; an error entry is pushed into the order FIFO.
REQ-016 Each grant SHALL push {err, sel} into the order FIFO (depth DEPTH) and increment outstanding[sel].
REQ-017 Each unit SHALL have a response FIFO of depth DEPTH with no backpressure. unit_rvalid_i[u] pushes {result, rflags} into it.
REQ-018 unit_rvalid_i[u] with outstanding[u] = 0 SHALL be dropped with no state change.
REQ-019 Retire: when the order-FIFO head is valid and its unit's response FIFO is non-empty, pop both, decrement outstanding, and drive the registered apu_rvalid_o/result/rflags the next cycle.
REQ-020 Error-entry retire: pops the order FIFO only. apu_result_o = 0; apu_rflags_o = APU_ROUTER_ERR_FLAGS.
REQ-021 Responses SHALL reach the core in grant order, whatever order the units complete in.
REQ-022 Minimum latency from unit_rvalid_i to apu_rvalid_o SHALL be 1 cycle; error entries retire 1 cycle after reaching the head.
REQ-023 At most one retire per cycle; apu_rvalid_o SHALL be a 1-cycle pulse per retired entry.
REQ-024 Grant and retire in the same cycle on the same unit SHALL leave outstanding[u] unchanged; the FIFO count SHALL be the old value +1 -1.
REQ-025 unit_clk_en_o[u] = (outstanding[u] != 0) | unit_req_o[u] | (response FIFO u non-empty).
REQ-026 Pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-027 rst_i asserted at any time SHALL clear both FIFOs, all outstanding counters and err_unit_o, and drive apu_rvalid_o, apu_result_o and apu_rflags_o to 0.
REQ-028 Unit responses arriving after reset for pre-reset requests SHALL be dropped per REQ-018.

Structure
REQ-029 APU_ROUTER_ERR_FLAGS (all-ones, NUSFLAGS wide) and the order-entry struct {err, sel} SHALL live in cv32e40p_apu_core_pkg.
REQ-030 A sub-module cv32e40p_apu_router_fifo (parametrised WIDTH and DEPTH, active-high asynchronous reset) SHALL implement the order FIFO and every response FIFO.

Verification
REQ-031 N_UNITS=2: op selects unit 1; unit_gnt_i=1, response result 0x1234 three cycles later -> apu_rvalid_o one cycle after the unit's rvalid, apu_result_o = 0x1234.
REQ-032 Requests to unit 0, then unit 1; unit 1 responds before unit 0 -> core sees unit 0's result first, then unit 1's, on consecutive or later cycles.
REQ-033 DEPTH=4: five grants to unit 0 with no responses -> fifth cycle apu_gnt_o = 0 and unit_req_o[0] = 0; one retire -> grant resumes the cycle after.
REQ-034 N_UNITS=3 with sel=3 -> apu_gnt_o = 1, err_unit_o = 1, response rdata 0 and rflags all-ones, in order behind earlier entries.
REQ-035 rst_i pulsed with 2 outstanding operations; the unit then responds -> no apu_rvalid_o, all unit_clk_en_o = 0.
REQ-036 Simultaneous retire and grant with the order FIFO full -> apu_gnt_o = 0 that cycle and 1 the next cycle.

Source files
------------

// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU widths and the router's order-entry type and error flags.
package cv32e40p_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;

  // Wide enough to name any unit of the largest router (four units).
  localparam int APU_ROUTER_SELW = 2;

  // Status flags returned to the core for a request aimed at a missing unit.
  localparam logic [APU_NUSFLAGS_CPU-1:0] APU_ROUTER_ERR_FLAGS = '1;

  // One entry per granted request, kept in grant order.
  typedef struct packed {
    logic                       err;
    logic [APU_ROUTER_SELW-1:0] sel;
  } apu_router_order_t;

  // Unit-select width; a single unit still gets one (ignored) bit.
  function automatic int apu_router_uw(input int n_units);
    return (n_units > 1) ? $clog2(n_units) : 1;
  endfunction

endpackage

// File: rtl/cv32e40p_apu_router_if.sv
// Core-side and unit-side APU signals bundled for the router.
interface cv32e40p_apu_router_if
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int N_UNITS = 2
);

  logic                                    apu_req_i;
  logic                                    apu_gnt_o;
  logic [APU_NARGS_CPU-1:0][31:0]          apu_operands_i;
  logic [APU_WOP_CPU-1:0]                  apu_op_i;
  logic [APU_NDSFLAGS_CPU-1:0]             apu_flags_i;
  logic                                    apu_rvalid_o;
  logic [31:0]                             apu_result_o;
  logic [APU_NUSFLAGS_CPU-1:0]             apu_rflags_o;

  logic [N_UNITS-1:0]                      unit_req_o;
  logic [N_UNITS-1:0]                      unit_gnt_i;
  logic [APU_NARGS_CPU-1:0][31:0]          unit_operands_o;
  logic [APU_WOP_CPU-1:0]                  unit_op_o;
  logic [APU_NDSFLAGS_CPU-1:0]             unit_flags_o;
  logic [N_UNITS-1:0]                      unit_rvalid_i;
  logic [N_UNITS-1:0][31:0]                unit_result_i;
  logic [N_UNITS-1:0][APU_NUSFLAGS_CPU-1:0] unit_rflags_i;

  // Router view: slave towards the core, master towards the units.
  modport slave (
    input  apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
    input  unit_gnt_i, unit_rvalid_i, unit_result_i, unit_rflags_i,
    output apu_gnt_o, apu_rvalid_o, apu_result_o, apu_rflags_o,
    output unit_req_o, unit_operands_o, unit_op_o, unit_flags_o
  );

  // Environment view: the core and the units around the router.
  modport master (
    output apu_req_i, apu_operands_i, apu_op_i, apu_flags_i,
    output unit_gnt_i, unit_rvalid_i, unit_result_i, unit_rflags_i,
    input  apu_gnt_o, apu_rvalid_o, apu_result_o, apu_rflags_o,
    input  unit_req_o, unit_operands_o, unit_op_o, unit_flags_o
  );

endinterface

// File: rtl/cv32e40p_apu_router_fifo.sv
// Small synchronous FIFO; an extra pointer bit separates full from empty.
module cv32e40p_apu_router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer advance; pushes into a full FIFO and pops from an empty one are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cv32e40p_apu_router.sv
// Routes core APU requests to one of several units and returns results in grant order.
module cv32e40p_apu_router
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int N_UNITS = 2,
  parameter int DEPTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  cv32e40p_apu_router_if.slave  bus,
  output logic [N_UNITS-1:0]    unit_clk_en_o,
  output logic                  err_unit_o
);

  localparam int UW = apu_router_uw(N_UNITS);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = 32 + APU_NUSFLAGS_CPU;
  localparam int OW = $bits(apu_router_order_t);

  logic [APU_ROUTER_SELW-1:0] sel;
  logic                       in_range;
  logic                       space;
  logic                       err_grant;
  logic                       grant;
  logic [CW-1:0]              sel_outstanding;
  logic [CW-1:0]              outstanding [N_UNITS];

  logic [N_UNITS-1:0] unit_req;
  logic [N_UNITS-1:0] unit_grant;
  logic [N_UNITS-1:0] accept;
  logic [N_UNITS-1:0] avail;
  logic [N_UNITS-1:0] resp_push;
  logic [N_UNITS-1:0] resp_pop;
  logic [N_UNITS-1:0] resp_full;
  logic [N_UNITS-1:0] resp_empty;
  logic [N_UNITS-1:0] retire_unit;
  logic [RW-1:0]      resp_rdata [N_UNITS];
  logic [RW-1:0]      unit_data  [N_UNITS];

  logic              order_full;
  logic              order_empty;
  logic [OW-1:0]     order_rdata;
  apu_router_order_t order_push_data;
  apu_router_order_t order_head;

  logic                        retire;
  logic [RW-1:0]               retire_data;
  logic                        rvalid_q;
  logic [31:0]                 result_q;
  logic [APU_NUSFLAGS_CPU-1:0] rflags_q;

  // Unit select from the top opcode bits; a single-unit router always targets unit 0.
  always_comb begin
    sel = '0;
    if (N_UNITS > 1) sel = APU_ROUTER_SELW'(bus.apu_op_i[APU_WOP_CPU-1 -: UW]);
  end

  assign in_range = (int'(sel) < N_UNITS);

  // Outstanding count of the selected unit; a missing unit counts as idle.
  always_comb begin
    sel_outstanding = '0;
    for (int u = 0; u < N_UNITS; u++) begin
      if (sel == APU_ROUTER_SELW'(u)) sel_outstanding = outstanding[u];
    end
  end

  assign space = ~order_full & (sel_outstanding < CW'(DEPTH));

  // Request only the selected unit, and only when its answer has somewhere to go.
  always_comb begin
    unit_req = '0;
    for (int u = 0; u < N_UNITS; u++) begin
      unit_req[u] = bus.apu_req_i & space & (sel == APU_ROUTER_SELW'(u));
    end
  end

  assign unit_grant = unit_req & bus.unit_gnt_i;
  assign err_grant  = bus.apu_req_i & space & ~in_range;
  assign grant      = (|unit_grant) | err_grant;

  assign bus.apu_gnt_o       = grant;
  assign bus.unit_req_o      = unit_req;
  assign bus.unit_operands_o = bus.apu_operands_i;
  assign bus.unit_op_o       = bus.apu_op_i;
  assign bus.unit_flags_o    = bus.apu_flags_i;

  // Order entry recorded for every grant, including requests to a missing unit.
  always_comb begin
    order_push_data     = '0;
    order_push_data.err = ~in_range;
    order_push_data.sel = sel;
  end

  cv32e40p_apu_router_fifo #(
    .WIDTH (OW),
    .DEPTH (DEPTH)
  ) i_order_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (grant),
    .wdata (order_push_data),
    .pop   (retire),
    .rdata (order_rdata),
    .full  (order_full),
    .empty (order_empty)
  );

  assign order_head = apu_router_order_t'(order_rdata);

  for (genvar gu = 0; gu < N_UNITS; gu++) begin : g_unit
    cv32e40p_apu_router_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
    ) i_resp_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (resp_push[gu]),
      .wdata ({bus.unit_result_i[gu], bus.unit_rflags_i[gu]}),
      .pop   (resp_pop[gu]),
      .rdata (resp_rdata[gu]),
      .full  (resp_full[gu]),
      .empty (resp_empty[gu])
    );
  end

  // Per-unit response availability; an empty FIFO lets a fresh response bypass it.
  always_comb begin
    accept = '0;
    avail  = '0;
    for (int u = 0; u < N_UNITS; u++) begin
      accept[u]    = bus.unit_rvalid_i[u] & (outstanding[u] != '0);
      avail[u]     = ~resp_empty[u] | accept[u];
      unit_data[u] = resp_empty[u] ? {bus.unit_result_i[u], bus.unit_rflags_i[u]}
                                   : resp_rdata[u];
    end
  end

  // Retire at most the order-FIFO head, once its response (or error status) is ready.
  always_comb begin
    retire      = 1'b0;
    retire_unit = '0;
    retire_data = '0;
    if (!order_empty) begin
      if (order_head.err) begin
        retire      = 1'b1;
        retire_data = {32'd0, APU_ROUTER_ERR_FLAGS};
      end else begin
        for (int u = 0; u < N_UNITS; u++) begin
          if ((order_head.sel == APU_ROUTER_SELW'(u)) && avail[u]) begin
            retire         = 1'b1;
            retire_unit[u] = 1'b1;
            retire_data    = unit_data[u];
          end
        end
      end
    end
  end

  // Response FIFO traffic; a bypassed response is consumed without being stored.
  always_comb begin
    resp_pop  = '0;
    resp_push = '0;
    for (int u = 0; u < N_UNITS; u++) begin
      resp_pop[u]  = retire_unit[u] & ~resp_empty[u];
      resp_push[u] = accept[u] & ~resp_full[u] & ~(retire_unit[u] & resp_empty[u]);
    end
  end

  // Outstanding counters; a grant and a retire on the same unit cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int u = 0; u < N_UNITS; u++) outstanding[u] <= '0;
    end else begin
      for (int u = 0; u < N_UNITS; u++) begin
        case ({unit_grant[u], retire_unit[u]})
          2'b10:   outstanding[u] <= outstanding[u] + CW'(1);
          2'b01:   outstanding[u] <= outstanding[u] - CW'(1);
          default: outstanding[u] <= outstanding[u];
        endcase
      end
    end
  end

  // Registered core response and sticky missing-unit flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q   <= 1'b0;
      result_q   <= '0;
      rflags_q   <= '0;
      err_unit_o <= 1'b0;
    end else begin
      rvalid_q <= retire;
      if (retire) {result_q, rflags_q} <= retire_data;
      if (err_grant) err_unit_o <= 1'b1;
    end
  end

  assign bus.apu_rvalid_o = rvalid_q;
  assign bus.apu_result_o = result_q;
  assign bus.apu_rflags_o = rflags_q;

  // Keep a unit clocked while it has work in flight, is being asked, or has results queued.
  always_comb begin
    unit_clk_en_o = '0;
    for (int u = 0; u < N_UNITS; u++) begin
      unit_clk_en_o[u] = (outstanding[u] != '0) | unit_req[u] | ~resp_empty[u];
    end
  end

endmodule

// File: tb/tb_cv32e40p_apu_router.sv
// Bench for the APU router with three units and four outstanding operations.
module tb_cv32e40p_apu_router;
  import cv32e40p_apu_core_pkg::*;

  localparam int N = 3;
  localparam int D = 4;

  typedef struct {
    bit err;
    int unit;
  } ord_t;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  fl;
  } rsp_t;

  logic clk;
  logic rst;
  logic [N-1:0] clk_en;
  logic err_unit;

  cv32e40p_apu_router_if #(.N_UNITS(N)) bus ();

  cv32e40p_apu_router #(.N_UNITS(N), .DEPTH(D)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
    .unit_clk_en_o (clk_en),
    .err_unit_o    (err_unit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: grant-ordered entries, per-unit in-flight counts and stored responses.
  ord_t   order_q [$];
  rsp_t   resp_q [N][$];
  int     out_cnt [N];
  int     pending [N];
  bit     err_model;
  bit     exp_valid;
  rsp_t   exp_rsp;

  int          compared;
  int          mismatched;
  logic        last_gnt;
  logic [N-1:0] last_req;
  logic [31:0] force_val [N];
  logic [N-1:0] force_en;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit req, input logic [1:0] sel,
                               input logic [N-1:0] gmask, input logic [N-1:0] vmask);
    logic [5:0]   op;
    logic [31:0]  opnd0;
    logic [14:0]  flags;
    logic [N-1:0] v;
    logic [N-1:0] exp_req;
    logic [N-1:0] exp_en;
    rsp_t         arr [N];
    bit           in_range;
    bit           space;
    bit           exp_gnt;
    int           s;
    int           h;

    op    = {sel, 4'($urandom)};
    opnd0 = $urandom;
    flags = 15'($urandom);
    bus.apu_req_i = req;
    bus.apu_op_i  = op;
    bus.apu_operands_i[0] = opnd0;
    bus.apu_operands_i[1] = $urandom;
    bus.apu_operands_i[2] = $urandom;
    bus.apu_flags_i = flags;
    bus.unit_gnt_i  = gmask;
    for (int u = 0; u < N; u++) begin
      v[u]       = vmask[u] && (pending[u] > 0);
      arr[u].res = force_en[u] ? force_val[u] : $urandom;
      arr[u].fl  = 5'($urandom);
      bus.unit_rvalid_i[u] = v[u];
      bus.unit_result_i[u] = arr[u].res;
      bus.unit_rflags_i[u] = arr[u].fl;
    end
    #1;

    s        = int'(sel);
    in_range = (s < N);
    space    = (order_q.size() < D);
    if (in_range && out_cnt[s] >= D) space = 1'b0;
    exp_req = '0;
    exp_gnt = 1'b0;
    if (req && space) begin
      if (in_range) begin
        exp_req[s] = 1'b1;
        exp_gnt    = gmask[s];
      end else begin
        exp_gnt = 1'b1;
      end
    end
    for (int u = 0; u < N; u++)
      exp_en[u] = (out_cnt[u] != 0) || exp_req[u] || (resp_q[u].size() != 0);

    last_gnt = bus.apu_gnt_o;
    last_req = bus.unit_req_o;
    checkOutput("gnt", 64'(bus.apu_gnt_o), 64'(exp_gnt));
    checkOutput("unit_req", 64'(bus.unit_req_o), 64'(exp_req));
    checkOutput("clk_en", 64'(clk_en), 64'(exp_en));
    checkOutput("unit_op", 64'(bus.unit_op_o), 64'(op));
    checkOutput("unit_opnd0", 64'(bus.unit_operands_o[0]), 64'(opnd0));
    checkOutput("unit_flags", 64'(bus.unit_flags_o), 64'(flags));
    checkOutput("err_unit", 64'(err_unit), 64'(err_model));
    checkOutput("rvalid", 64'(bus.apu_rvalid_o), 64'(exp_valid));
    if (exp_valid) begin
      checkOutput("result", 64'(bus.apu_result_o), 64'(exp_rsp.res));
      checkOutput("rflags", 64'(bus.apu_rflags_o), 64'(exp_rsp.fl));
    end

    for (int u = 0; u < N; u++) begin
      if (v[u]) begin
        pending[u]--;
        if (out_cnt[u] != 0) resp_q[u].push_back(arr[u]);
      end
    end
    exp_valid = 1'b0;
    if (order_q.size() > 0) begin
      if (order_q[0].err) begin
        exp_valid  = 1'b1;
        exp_rsp.res = '0;
        exp_rsp.fl  = '1;
        void'(order_q.pop_front());
      end else begin
        h = order_q[0].unit;
        if (resp_q[h].size() > 0) begin
          exp_valid = 1'b1;
          exp_rsp   = resp_q[h].pop_front();
          void'(order_q.pop_front());
          out_cnt[h]--;
        end
      end
    end
    if (exp_gnt) begin
      order_q.push_back('{err: !in_range, unit: s});
      if (in_range) begin
        out_cnt[s]++;
        pending[s]++;
      end else begin
        err_model = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Reset pulse; the units keep whatever responses they still owe.
  task automatic do_reset();
    rst = 1'b1;
    bus.apu_req_i     = 1'b0;
    bus.unit_gnt_i    = '0;
    bus.unit_rvalid_i = '0;
    @(negedge clk);
    @(negedge clk);
    order_q.delete();
    for (int u = 0; u < N; u++) begin
      resp_q[u].delete();
      out_cnt[u] = 0;
    end
    err_model = 1'b0;
    exp_valid = 1'b0;
    checkOutput("rst_rvalid", 64'(bus.apu_rvalid_o), 64'(0));
    checkOutput("rst_result", 64'(bus.apu_result_o), 64'(0));
    checkOutput("rst_rflags", 64'(bus.apu_rflags_o), 64'(0));
    checkOutput("rst_err", 64'(err_unit), 64'(0));
    checkOutput("rst_clk_en", 64'(clk_en), 64'(0));
    rst = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    force_en   = '0;
    for (int u = 0; u < N; u++) begin
      pending[u]   = 0;
      force_val[u] = '0;
    end
    rst = 1'b1;
    bus.apu_req_i      = 1'b0;
    bus.apu_op_i       = '0;
    bus.apu_operands_i = '0;
    bus.apu_flags_i    = '0;
    bus.unit_gnt_i     = '0;
    bus.unit_rvalid_i  = '0;
    bus.unit_result_i  = '0;
    bus.unit_rflags_i  = '0;
    @(negedge clk);
    do_reset();
    applyStimulus(0, 0, '0, '0);

    $display("[TB] single request to unit 1, answered three cycles later");
    applyStimulus(1, 1, '1, '0);
    applyStimulus(0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0);
    force_en = 3'b010; force_val[1] = 32'h1234;
    applyStimulus(0, 0, '0, 3'b010);
    force_en = '0;
    checkOutput("r031_rvalid", 64'(bus.apu_rvalid_o), 64'(1));
    checkOutput("r031_result", 64'(bus.apu_result_o), 64'(32'h1234));
    applyStimulus(0, 0, '0, '0);

    $display("[TB] unit 1 completes before unit 0");
    applyStimulus(1, 0, '1, '0);
    applyStimulus(1, 1, '1, '0);
    force_en = 3'b011; force_val[1] = 32'hB1B1_0001; force_val[0] = 32'hA0A0_0000;
    applyStimulus(0, 0, '0, 3'b010);
    checkOutput("r032_hold", 64'(bus.apu_rvalid_o), 64'(0));
    applyStimulus(0, 0, '0, 3'b001);
    force_en = '0;
    checkOutput("r032_first", 64'(bus.apu_result_o), 64'(32'hA0A0_0000));
    applyStimulus(0, 0, '0, '0);
    checkOutput("r032_second_v", 64'(bus.apu_rvalid_o), 64'(1));
    checkOutput("r032_second", 64'(bus.apu_result_o), 64'(32'hB1B1_0001));
    applyStimulus(0, 0, '0, '0);

    $display("[TB] fill to depth, then retire and grant together");
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, '1, '0);
    checkOutput("r033_gnt_full", 64'(last_gnt), 64'(0));
    checkOutput("r033_req_full", 64'(last_req[0]), 64'(0));
    applyStimulus(1, 0, '1, 3'b001);
    checkOutput("r036_gnt_retire", 64'(last_gnt), 64'(0));
    applyStimulus(1, 0, '1, '0);
    checkOutput("r036_gnt_after", 64'(last_gnt), 64'(1));
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 3'b001);
    applyStimulus(0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0);

    $display("[TB] request to a missing unit behind a real one");
    applyStimulus(1, 2, '1, '0);
    applyStimulus(1, 3, '1, '0);
    checkOutput("r034_gnt", 64'(last_gnt), 64'(1));
    checkOutput("r034_req", 64'(last_req), 64'(0));
    checkOutput("r034_err", 64'(err_unit), 64'(1));
    force_en = 3'b100; force_val[2] = 32'h0000_2222;
    applyStimulus(0, 0, '0, 3'b100);
    force_en = '0;
    checkOutput("r034_first", 64'(bus.apu_result_o), 64'(32'h2222));
    applyStimulus(0, 0, '0, '0);
    checkOutput("r034_err_v", 64'(bus.apu_rvalid_o), 64'(1));
    checkOutput("r034_err_res", 64'(bus.apu_result_o), 64'(0));
    checkOutput("r034_err_fl", 64'(bus.apu_rflags_o), 64'(5'h1f));
    applyStimulus(0, 0, '0, '0);

    $display("[TB] reset with two operations in flight");
    do_reset();
    applyStimulus(1, 0, '1, '0);
    applyStimulus(1, 0, '1, '0);
    do_reset();
    applyStimulus(0, 0, '0, 3'b001);
    applyStimulus(0, 0, '0, 3'b001);
    checkOutput("r035_rvalid", 64'(bus.apu_rvalid_o), 64'(0));
    checkOutput("r035_clk_en", 64'(clk_en), 64'(0));
    applyStimulus(0, 0, '0, '0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom), 2'($urandom), 3'($urandom), 3'($urandom));
    end
    for (int i = 0; i < 30; i++) applyStimulus(0, 0, '0, '1);
    checkOutput("drain_clk_en", 64'(clk_en), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
